demux_dispatcher: RTL and testbench
===================================

// Module: demux_dispatcher
// PURPOSE
//  Sequencer for the 1-to-8 demultiplexer datapath. Accepts a valid/ready word stream and drives
//  the 3-bit select plus one-hot per-output valid. Delivers each word to exactly one of 8 consumers,
//  either round-robin over ready consumers or by explicit destination.
//  Sits between a single producer and eight sink ports.
// PARAMETERS
//  DATA_W   8   width of in_data/out_data
//  NUM_OUT  8   consumer count, 2..8; select width fixed at 3
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  in_valid  in   1        producer word valid
//  in_ready  out  1        dispatcher can accept a word this cycle
//  in_data   in   DATA_W   producer word
//  in_dest   in   3        target index, used when mode=1
//  mode      in   1        0 = round-robin, 1 = directed; sampled only at acceptance
//  sel       out  3        select for the demux; index of held word's target
//  out_valid out  NUM_OUT  one-hot valid, bit sel asserted while holding
//  out_data  out  DATA_W   held word, shared by all consumers
//  out_ready in   NUM_OUT  per-consumer ready
//  drop      out  1        1-cycle pulse: a directed word with in_dest >= NUM_OUT was discarded
// BEHAVIOUR
//  Reset values: sel=0, out_valid=0, out_data=0, drop=0, in_ready=1, state=IDLE, rr_ptr=0.
//  States:
//   - IDLE: nothing held.
//   - HOLD: one word registered, out_valid[sel]=1.
//  in_ready = (state==IDLE) | out_ready[sel]. Combinational from out_ready; no skid buffer.
//  Accept (in_valid & in_ready) captures in_data and the target into registers. Latency is 1 cycle.
//  Target when mode=0: first index i>=rr_ptr (wrapping mod NUM_OUT) with out_ready[i]=1.
//   - If none is ready, target = rr_ptr.
//  Target when mode=1: in_dest.
//   - in_dest >= NUM_OUT: word consumed, drop=1 next cycle, state unchanged.
//  HOLD -> IDLE on out_ready[sel] with no accept the same cycle. The word is then delivered.
//  Delivery and accept in the same cycle: the new word loads directly. HOLD is kept with no bubble,
//   so throughput is 1 word/cycle.
//  rr_ptr <= sel+1 (wrap NUM_OUT-1 -> 0) on each delivery of a mode-0 word. Directed words
//   leave rr_ptr unchanged.
//  Back-to-back round-robin picks use the already-updated pointer (sel+1) as base.
//  While holding:
//   - out_data and sel are stable.
//   - out_valid never retracts.
//   - mode/in_dest changes do not affect the held word.
//  out_ready on non-selected outputs is ignored while holding.
//  Reset asserted mid-HOLD: the held word is discarded, all outputs go to reset values immediately.
// CONFIGURATION
//  DEMUX_DISPATCHER_STATS_EN defined:
//   - Adds inputs stat_idx[2:0] and stat_clr, and output stat_cnt[15:0].
//   - Holds one 16-bit delivery counter per output. Each counter increments on delivery and
//     saturates at 16'hFFFF.
//   - stat_cnt = counter[stat_idx], combinational. Indices >= NUM_OUT read 0.
//   - stat_clr zeroes all counters synchronously. Clear wins over a same-cycle increment.
//   - Counters reset to 0 on rst_n.
//  Undefined: no stats ports, no counters; dispatch behaviour is identical.
// STRUCTURE
//  Package demux_dispatcher_pkg:
//   - SEL_W=3 localparam.
//   - state_t enum {IDLE, HOLD}.
//   - MODE_RR/MODE_DIR constants.
//   - STAT_W=16.
//  Sub-module rr_pick: pure combinational rotate-priority finder.
//   - Inputs req[NUM_OUT-1:0] and base[2:0]; outputs idx[2:0] and found.
//   - Instantiated once for the mode-0 target.
//  Top holds the FSM, data/sel registers, rr_ptr, drop pulse and the optional counters.
// TESTING
//  1 Reset, mode=0, all out_ready=1, 8 back-to-back words 0x10..0x17
//     -> delivered to outputs 0..7 in order, 1/cycle, in_ready held 1.
//  2 mode=0, rr_ptr=2, out_ready=8'b1000_0001, word 0xA5 -> sel=7.
//     Then on delivery rr_ptr=0, and the next word goes to output 0.
//  3 mode=1, in_dest=5, out_ready[5]=0 for 4 cycles
//     -> out_valid=8'b0010_0000 stable, in_ready=0, out_data stable.
//     Delivery on the 5th cycle.
//  4 NUM_OUT=6, mode=1, in_dest=6 -> no out_valid, drop pulses 1 cycle.
//     The next word is accepted normally.
//  5 Assert rst_n=0 mid-HOLD -> out_valid=0, sel=0 immediately.
//     After release, word 0x3C in mode=0 goes to output 0.
//  6 STATS_EN: deliver 3 words to output 4, stat_idx=4 -> stat_cnt=3.
//     stat_clr concurrent with a delivery to 4 -> stat_cnt=0.

Source files
------------

// File: rtl/demux_dispatcher_pkg.sv
// demux_dispatcher_pkg: shared types and constants for the 1-to-8 demux dispatcher
package demux_dispatcher_pkg;
    localparam int SEL_W = 3;
    localparam int STAT_W = 16;
    localparam logic MODE_RR = 1'b0;
    localparam logic MODE_DIR = 1'b1;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/demux_dispatcher_rr_pick.sv
// demux_dispatcher_rr_pick: rotate-priority finder, first set req bit at or after base (wrapping)
//   req   in  NUM_OUT  request/ready vector
//   base  in  3        starting index, assumed < NUM_OUT
//   idx   out 3        winning index (base when nothing is set)
//   found out 1        some req bit was set
module demux_dispatcher_rr_pick
    import demux_dispatcher_pkg::*;
#(
    parameter int NUM_OUT = 8
) (
    input  logic [NUM_OUT-1:0] req,
    input  logic [SEL_W-1:0]   base,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);
    // Scan offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        idx = base;
        found = 1'b0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (req[(int'(base) + k) % NUM_OUT]) begin
                idx = SEL_W'((int'(base) + k) % NUM_OUT);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: valid/ready sequencer steering each word to one of NUM_OUT consumers
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready producer handshake; in_data word, in_dest directed target, mode 0=rr 1=directed
//   sel, out_valid    demux select and one-hot valid of the held word
//   out_data          held word; out_ready per-consumer ready
//   drop              one-cycle pulse when a directed word with out-of-range dest is discarded
//   DEMUX_DISPATCHER_STATS_EN adds stat_idx/stat_clr inputs and stat_cnt output (per-output
//   saturating delivery counters)
module demux_dispatcher
    import demux_dispatcher_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_dest,
    input  logic               mode,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               drop
`ifdef DEMUX_DISPATCHER_STATS_EN
    ,
    input  logic [SEL_W-1:0]   stat_idx,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  stat_cnt
`endif
);
    state_t state;
    logic held_mode;
    logic [SEL_W-1:0] rr_ptr, next_sel, base, pick_idx, tgt;
    logic pick_found, deliver, accept, drop_acc, load;
    logic [NUM_OUT-1:0] tgt_oh;

    assign in_ready = (state == IDLE) | out_ready[sel];
    assign deliver = (state == HOLD) & out_ready[sel];
    assign accept = in_valid & in_ready;
    assign drop_acc = accept & (mode == MODE_DIR) & ({1'b0, in_dest} >= 4'(NUM_OUT));
    assign load = accept & ~drop_acc;
    assign next_sel = (sel == SEL_W'(NUM_OUT - 1)) ? '0 : sel + SEL_W'(1);
    // A round-robin word delivered this cycle already advances the pointer for a same-cycle pick.
    assign base = (deliver && held_mode == MODE_RR) ? next_sel : rr_ptr;
    assign tgt = (mode == MODE_DIR) ? in_dest : (pick_found ? pick_idx : base);
    assign tgt_oh = NUM_OUT'(1) << tgt;

    demux_dispatcher_rr_pick #(.NUM_OUT(NUM_OUT)) rr_pick (
        .req(out_ready),
        .base(base),
        .idx(pick_idx),
        .found(pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= '0;
            out_valid <= '0;
            out_data <= '0;
            drop <= 1'b0;
            rr_ptr <= '0;
            held_mode <= MODE_RR;
        end else begin
            drop <= drop_acc;
            if (deliver && held_mode == MODE_RR)
                rr_ptr <= next_sel;
            if (load) begin
                state <= HOLD;
                sel <= tgt;
                out_data <= in_data;
                held_mode <= mode;
                out_valid <= tgt_oh;
            end else if (deliver) begin
                state <= IDLE;
                out_valid <= '0;
            end
        end
    end

`ifdef DEMUX_DISPATCHER_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (stat_clr)
                    cnt[i] <= '0;
                else if (deliver && sel == SEL_W'(i) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + STAT_W'(1);
            end
        end
    end

    assign stat_cnt = ({1'b0, stat_idx} < 4'(NUM_OUT)) ? cnt[stat_idx] : '0;
`endif
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed scenarios plus random traffic against a queue-free reference model
module tb_demux_dispatcher;
    localparam int N = 6;
    localparam int DW = 8;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, mode = 0;
    logic [DW-1:0] in_data = 0;
    logic [2:0] in_dest = 0;
    logic [N-1:0] out_ready = 0;
    logic in_ready, drop;
    logic [2:0] sel;
    logic [N-1:0] out_valid;
    logic [DW-1:0] out_data;
`ifdef DEMUX_DISPATCHER_STATS_EN
    logic [2:0] stat_idx = 0;
    logic stat_clr = 0;
    logic [15:0] stat_cnt;
    int m_cnt [N];
`endif

    int n_checks = 0, n_errors = 0;
    int m_held, m_sel, m_data, m_mode, m_rr, m_drop;

    always #5 clk = ~clk;

    demux_dispatcher #(.DATA_W(DW), .NUM_OUT(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .mode(mode), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .drop(drop)
`ifdef DEMUX_DISPATCHER_STATS_EN
        , .stat_idx(stat_idx), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_target(input int base, input logic [N-1:0] rdy);
        for (int k = 0; k < N; k++)
            if (rdy[(base + k) % N]) return (base + k) % N;
        return base;
    endfunction

    task automatic model_reset();
        m_held = 0; m_sel = 0; m_data = 0; m_mode = 0; m_rr = 0; m_drop = 0;
`ifdef DEMUX_DISPATCHER_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    endtask

    // Inputs are set by the caller shortly after a rising edge; this checks in_ready, advances
    // the model across the next edge and checks the registered outputs.
    task automatic step();
        bit rdy, acc, dlv, drp;
        int tgt;
        #2;
        rdy = !m_held || out_ready[m_sel];
        check("in_ready", in_ready, rdy);
        dlv = m_held && out_ready[m_sel];
        acc = in_valid && rdy;
        drp = acc && mode && in_dest >= N;
`ifdef DEMUX_DISPATCHER_STATS_EN
        if (stat_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        else if (dlv && m_cnt[m_sel] < 16'hFFFF) m_cnt[m_sel]++;
`endif
        if (dlv && m_mode == 0) m_rr = (m_sel + 1) % N;
        tgt = mode ? int'(in_dest) : rr_target(m_rr, out_ready);
        if (acc && !drp) begin
            m_held = 1; m_sel = tgt; m_data = in_data; m_mode = mode;
        end else if (dlv) m_held = 0;
        m_drop = drp;
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_held ? (1 << m_sel) : 0);
        if (m_held) begin
            check("sel", sel, m_sel);
            check("out_data", out_data, m_data);
        end
        check("drop", drop, m_drop);
`ifdef DEMUX_DISPATCHER_STATS_EN
        check("stat_cnt", stat_cnt, stat_idx < N ? m_cnt[stat_idx] : 0);
`endif
    endtask

    // Reset is asserted away from any edge and must clear outputs without waiting for a clock.
    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_drop", drop, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [2:0] d, input logic [DW-1:0] w);
        in_valid = 1; mode = m; in_dest = d; in_data = w;
        step();
        in_valid = 0;
    endtask

    initial begin
        #3;
        do_reset();
        // back-to-back round robin, all ready: outputs 0..N-1 in order
        out_ready = '1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1; mode = 0; in_data = DW'(8'h10 + i);
            step();
            check("t1_sel", sel, i);
        end
        in_valid = 0;
        step();
        // rr pointer to 2, then skip to the only ready output above it
        send(0, 0, 8'h01);
        send(0, 0, 8'h02);
        step();
        out_ready = 6'b100001;
        send(0, 0, 8'hA5);
        check("t2_sel", sel, 5);
        send(0, 0, 8'h5A);
        check("t2_wrap_sel", sel, 0);
        step();
        // directed word stalled four cycles on a busy consumer
        out_ready = '1;
        out_ready[5] = 0;
        send(1, 5, 8'hC3);
        in_valid = 1; mode = 0; in_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hold", out_valid, 6'b100000);
        end
        in_valid = 0;
        out_ready = '1;
        step();
        check("t3_deliver", out_valid, 0);
        // out-of-range directed destinations are dropped
        send(1, 6, 8'hEE);
        check("t4_drop", drop, 1);
        send(1, 7, 8'hEF);
        send(1, 2, 8'h42);
        check("t4_next", out_valid, 6'b000100);
        step();
        // reset mid-hold, then round robin restarts at 0
        out_ready = 0;
        send(0, 0, 8'h99);
        do_reset();
        out_ready = '1;
        send(0, 0, 8'h3C);
        check("t5_sel", sel, 0);
        step();
`ifdef DEMUX_DISPATCHER_STATS_EN
        stat_idx = 4;
        for (int i = 0; i < 3; i++) send(1, 4, DW'(i));
        step();
        check("t6_cnt3", stat_cnt, 3);
        send(1, 4, 8'h44);
        stat_clr = 1;
        step();
        stat_clr = 0;
        check("t6_clr", stat_cnt, 0);
`endif
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 1);
            in_dest = $urandom_range(0, 7);
            in_data = DW'($urandom);
            out_ready = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
`ifdef DEMUX_DISPATCHER_STATS_EN
            stat_idx = $urandom_range(0, 7);
            stat_clr = ($urandom_range(0, 63) == 0);
`endif
            step();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
